// File: rtl/registers.sv
// Edge-triggered storage register with true and complementary outputs.
// Synchronous active-low reset loads RESET_VALUE; WIDTH bits are independent.
module registers #(
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic [WIDTH-1:0] stored;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stored <= RESET_VALUE;
        end else begin
            stored <= D;
        end
    end

    // Complement comes straight off the stored value so Q and Qbar never disagree
    assign Q    = stored;
    assign Qbar = ~stored;

endmodule

// File: tb/tb_registers.sv
// Directed bench for registers: 1-bit default instance plus a 32-bit
// instance with a non-zero reset value, checked mid-cycle after edges.
module tb_registers;

    localparam logic [31:0] WIDE_RESET = 32'h1234_5678;

    logic        clock;
    logic        reset;
    logic [0:0]  d;
    logic [0:0]  q;
    logic [0:0]  qBar;
    logic [31:0] wideD;
    logic [31:0] wideQ;
    logic [31:0] wideQbar;

    int vecCount = 0;
    int errCount = 0;

    registers dutBit (
        .clock (clock),
        .reset (reset),
        .D     (d),
        .Q     (q),
        .Qbar  (qBar)
    );

    registers #(
        .WIDTH       (32),
        .RESET_VALUE (WIDE_RESET)
    ) dutWide (
        .clock (clock),
        .reset (reset),
        .D     (wideD),
        .Q     (wideQ),
        .Qbar  (wideQbar)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic edgeMid();
        @(posedge clock);
        #5;
    endtask

    initial begin
        reset = 1'b0;
        d     = 1'b1;
        wideD = 32'hFFFF_FFFF;

        // Reset held for two edges while D is high
        edgeMid();
        edgeMid();
        checkVal("rstQ", {31'b0, q}, 32'd0);
        checkVal("rstQbar", {31'b0, qBar}, 32'd1);
        checkVal("wideRstQ", wideQ, WIDE_RESET);
        checkVal("wideRstQbar", wideQbar, ~WIDE_RESET);

        @(negedge clock);
        reset = 1'b1;
        repeat (5) edgeMid();
        checkVal("loadQ", {31'b0, q}, 32'd1);
        checkVal("loadQbar", {31'b0, qBar}, 32'd0);
        checkVal("wideLoadQ", wideQ, 32'hFFFF_FFFF);

        // D glitch straddling the falling edge must not be captured
        #3 d = 1'b0;
        #4 d = 1'b1;
        #3;
        checkVal("glitchMid", {31'b0, q}, 32'd1);
        repeat (5) edgeMid();
        checkVal("glitchQ", {31'b0, q}, 32'd1);
        checkVal("glitchQbar", {31'b0, qBar}, 32'd0);

        @(negedge clock);
        d = 1'b0;
        #5;
        checkVal("holdNoEdge", {31'b0, q}, 32'd1);
        edgeMid();
        checkVal("latencyQ", {31'b0, q}, 32'd0);
        repeat (4) edgeMid();
        checkVal("zeroQ", {31'b0, q}, 32'd0);
        checkVal("zeroQbar", {31'b0, qBar}, 32'd1);

        @(negedge clock);
        d = 1'b1;
        edgeMid();
        checkVal("reloadQ", {31'b0, q}, 32'd1);

        // Mid-cycle reset must wait for the next rising edge
        reset = 1'b0;
        #3;
        checkVal("syncRstBefore", {31'b0, q}, 32'd1);
        checkVal("wideSyncRstBefore", wideQ, 32'hFFFF_FFFF);
        edgeMid();
        checkVal("syncRstQ", {31'b0, q}, 32'd0);
        checkVal("syncRstQbar", {31'b0, qBar}, 32'd1);
        checkVal("wideSyncRstQ", wideQ, WIDE_RESET);
        reset = 1'b1;
        edgeMid();
        checkVal("releaseQ", {31'b0, q}, 32'd1);
        checkVal("wideReleaseQ", wideQ, 32'hFFFF_FFFF);

        @(negedge clock);
        wideD = 32'hA5A5_5A5A;
        edgeMid();
        checkVal("widePatQ", wideQ, 32'hA5A5_5A5A);
        checkVal("widePatQbar", wideQbar, 32'h5A5A_A5A5);

        // Reset sampled low wins over a new D at the same edge
        @(negedge clock);
        reset = 1'b0;
        wideD = 32'h0F0F_0F0F;
        edgeMid();
        checkVal("wideRstWins", wideQ, WIDE_RESET);
        @(negedge clock);
        reset = 1'b1;
        wideD = 32'h8000_0001;
        edgeMid();
        checkVal("wideFirstLoad", wideQ, 32'h8000_0001);
        checkVal("wideFirstLoadBar", wideQbar, 32'h7FFF_FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
